// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor: out = a - b, LSB first.
// One operation at a time via start/busy/done; result lands after WIDTH edges.
module sub_serial #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] res_nxt;

  // One full-adder slice on the current LSBs; the new sum bit enters from the MSB side
  always_comb begin
    sum_bit   = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
    carry_out = (sh_a_q[0] & sh_b_q[0])
              | (sh_a_q[0] & carry_q)
              | (sh_b_q[0] & carry_q);
    res_nxt   = {sum_bit, res_q};
  end

  // Next-state logic: accept in IDLE, shift one bit per edge in RUN
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sh_a_d  = a;
          sh_b_d  = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        carry_d = carry_out;
        res_d   = res_nxt[WIDTH-1:1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          out_d   = res_nxt;
          // MSB slice: carry in != carry out means signed overflow
          ovf_d   = carry_q ^ carry_out;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign out      = out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed and exhaustive checks for sub_serial (WIDTH=6).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_sub_serial;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         overflow;

  int n_cmp;
  int n_bad;

  sub_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for done after the accepting edge; reports latency/busy count
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issues one operation with a one-cycle start pulse
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nbusy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, out, overflow} !== {1'b0, 1'b0, 6'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b out=%h ovf=%b want 0/0/00/0",
               busy, done, out, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, nb;
    do_op(6'd5, 6'd3, lat, nb);
    n_cmp++;
    if (lat !== W) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want %0d", lat, W);
    end
    n_cmp++;
    if (nb !== W) begin
      n_bad++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", nb, W);
    end
    n_cmp++;
    if ({out, overflow} !== {6'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_5m3: out=%0d ovf=%b want 2/0", out, overflow);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, out} !== {1'b0, 1'b0, 6'd2}) begin
      n_bad++;
      $display("FAIL done_pulse: done=%b busy=%b out=%0d want 0/0/2",
               done, busy, out);
    end
  endtask

  task automatic test_boundaries();
    int lat, nb;
    do_op(6'b100000, 6'd1, lat, nb);
    n_cmp++;
    if ({out, overflow} !== {6'd31, 1'b1}) begin
      n_bad++;
      $display("FAIL m32_minus_1: out=%h ovf=%b want 1f/1", out, overflow);
    end
    do_op(6'd31, 6'b111111, lat, nb);
    n_cmp++;
    if ({out, overflow} !== {6'b100000, 1'b1}) begin
      n_bad++;
      $display("FAIL 31_minus_m1: out=%h ovf=%b want 20/1", out, overflow);
    end
    do_op(6'b100000, 6'b100000, lat, nb);
    n_cmp++;
    if ({out, overflow} !== {6'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL m32_minus_m32: out=%h ovf=%b want 00/0", out, overflow);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, nb;
    @(negedge clk);
    start = 1'b1;
    a     = 6'd5;
    b     = 6'd3;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    start = 1'b1;
    a     = 6'd9;
    b     = 6'd1;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    wait_done(lat, nb);
    n_cmp++;
    if (lat !== W - 2) begin
      n_bad++;
      $display("FAIL ignore_latency: got %0d want %0d", lat, W - 2);
    end
    n_cmp++;
    if ({out, overflow} !== {6'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL ignore_result: out=%0d ovf=%b want 2/0", out, overflow);
    end
  endtask

  task automatic test_start_in_done();
    int lat, nb;
    do_op(6'd5, 6'd3, lat, nb);
    start = 1'b1;
    a     = 6'd0;
    b     = 6'b100000;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({done, busy, out} !== {1'b0, 1'b1, 6'd2}) begin
      n_bad++;
      $display("FAIL done_start_accept: done=%b busy=%b out=%0d want 0/1/2",
               done, busy, out);
    end
    wait_done(lat, nb);
    n_cmp++;
    if (lat !== W) begin
      n_bad++;
      $display("FAIL done_start_latency: got %0d want %0d", lat, W);
    end
    n_cmp++;
    if ({out, overflow} !== {6'b100000, 1'b1}) begin
      n_bad++;
      $display("FAIL 0_minus_m32: out=%h ovf=%b want 20/1", out, overflow);
    end
  endtask

  task automatic test_reset_midop();
    int lat, nb;
    @(negedge clk);
    start = 1'b1;
    a     = 6'd5;
    b     = 6'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, out, overflow} !== {1'b0, 1'b0, 6'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL midop_reset: busy=%b done=%b out=%h ovf=%b want 0/0/00/0",
               busy, done, out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(6'd7, 6'd2, lat, nb);
    n_cmp++;
    if ({out, overflow} !== {6'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL after_reset_op: out=%0d ovf=%b want 5/0", out, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, k;
    t0 = -1;
    t1 = -1;
    k  = 0;
    @(negedge clk);
    start = 1'b1;
    a     = 6'd10;
    b     = 6'b111101;
    while (t1 < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (done) begin
        n_cmp++;
        if (out !== 6'd13) begin
          n_bad++;
          $display("FAIL b2b_result: out=%0d want 13", out);
        end
        if (t0 < 0) t0 = k;
        else t1 = k;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (t1 - t0 !== W + 1) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d want %0d (t0=%0d t1=%0d)",
               t1 - t0, W + 1, t0, t1);
    end
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    int lat, nb, d;
    logic [W-1:0] ea;
    logic         ev;
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        do_op(W'(i), W'(j), lat, nb);
        d  = int'($signed(W'(i))) - int'($signed(W'(j)));
        ea = W'(d);
        ev = (d < -32) || (d > 31);
        n_cmp++;
        if ({out, overflow} !== {ea, ev}) begin
          n_bad++;
          $display("FAIL exh a=%0d b=%0d: out=%0d ovf=%b want %0d/%b lat=%0d",
                   $signed(W'(i)), $signed(W'(j)), $signed(out), overflow,
                   $signed(ea), ev, lat);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_busy_ignore();
    test_start_in_done();
    test_reset_midop();
    test_back_to_back();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
